// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requesters onto one single-port memory, one transaction in flight.
// Grant is combinational in IDLE; mem_* registered and held until mem_ready; rvalid one cycle after mem_rvalid.
module mem_arbiter #(
  parameter int unsigned MAX_DM_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, REQ_IF, REQ_DM, RSP_IF, RSP_DM} state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_DM_BURST);

  state_t     state, state_nxt;
  logic [3:0] burst_cnt;
  logic       burst_full;
  logic       in_rsp;

  assign burst_full = (burst_cnt == BURST_MAX);
  assign in_rsp     = (state == RSP_IF) || (state == RSP_DM);

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    case (state)
      IDLE: begin
        // Data normally wins; a fetch starved for a full burst takes the next slot.
        if (!rst) begin
          if (if_req && (!dm_req || burst_full)) begin
            if_gnt    = 1'b1;
            state_nxt = REQ_IF;
          end else if (dm_req) begin
            dm_gnt    = 1'b1;
            state_nxt = REQ_DM;
          end
        end
      end
      REQ_IF:  if (mem_ready)  state_nxt = RSP_IF;
      REQ_DM:  if (mem_ready)  state_nxt = RSP_DM;
      RSP_IF:  if (mem_rvalid) state_nxt = IDLE;
      RSP_DM:  if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rvalid <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      state     <= state_nxt;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;

      if (if_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_be    <= 4'hF;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end else if (dm_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_be    <= dm_be;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (mem_ready && (state == REQ_IF || state == REQ_DM)) begin
        mem_req   <= 1'b0;
      end

      // mem_we still describes the in-flight data access, so stores return zero.
      if (state == RSP_IF && mem_rvalid) begin
        if_rvalid <= 1'b1;
        if_rdata  <= mem_rdata;
      end
      if (state == RSP_DM && mem_rvalid) begin
        dm_rvalid <= 1'b1;
        dm_rdata  <= mem_we ? 32'h0 : mem_rdata;
      end

      if (mem_rvalid && !in_rsp) err <= 1'b1;

      if (state == IDLE) begin
        if (if_gnt || !if_req)          burst_cnt <= '0;
        else if (dm_gnt && !burst_full) burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter: a reference memory and grant-order model feed
// expectation queues that an independent negedge monitor pops when the DUT responds.
module tb_mem_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_DM_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err(err)
  );

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mtx_t;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  logic [31:0] ref_mem [1024];
  logic [31:0] dev_mem [1024];
  mtx_t        mq[$];
  logic [31:0] q_if[$], q_dm[$];
  int          gseq[$];
  bit          m_busy = 0, gnt_fast = 0;
  int          streak = 0, gnt_cyc = 0;

  int  ready_pct = 100, rsp_min = 0, rsp_max = 0, if_pct = 0, dm_pct = 0;
  bit  rand_on = 0, if_taken = 0, dm_taken = 0;
  bit  hs = 0, hs_we = 0, rsp_pend = 0;
  logic [3:0]  hs_be;
  logic [31:0] hs_addr, hs_wdata, rsp_dat;
  int  rsp_cnt = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bad(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Reference: expected grant, memory request and response per the arbitration rules.
  always @(negedge clk) begin : mon
    logic e_if, e_dm;
    mtx_t t;
    if (rst) begin
      mq.delete(); q_if.delete(); q_dm.delete();
      m_busy = 0;
      streak = 0;
      chk("gnt_in_rst", {if_gnt, dm_gnt}, 0);
    end else begin
      if (if_rvalid) begin
        if (q_if.size() == 0) bad("if_rvalid_unexpected");
        else chk("if_rdata", if_rdata, q_if.pop_front());
        if (gnt_fast) chk("if_latency", 96'(cyc - gnt_cyc), 96'(3));
        m_busy = 0;
      end
      if (dm_rvalid) begin
        if (q_dm.size() == 0) bad("dm_rvalid_unexpected");
        else chk("dm_rdata", dm_rdata, q_dm.pop_front());
        if (gnt_fast) chk("dm_latency", 96'(cyc - gnt_cyc), 96'(3));
        m_busy = 0;
      end

      e_if = 0;
      e_dm = 0;
      if (!m_busy && (if_req || dm_req)) begin
        if (if_req && (!dm_req || streak == MAXB)) e_if = 1;
        else e_dm = 1;
      end
      chk("gnt", {if_gnt, dm_gnt}, {e_if, e_dm});
      if (!m_busy) begin
        if (!if_req || e_if) streak = 0;
        else if (e_dm && streak < MAXB) streak++;
      end
      if (e_if || e_dm) begin
        m_busy   = 1;
        gnt_cyc  = cyc;
        gnt_fast = (ready_pct == 100 && rsp_max == 0);
      end
      if (e_if) begin
        mq.push_back('{we: 1'b0, be: 4'hF, addr: if_addr, wdata: 32'h0});
        q_if.push_back(ref_mem[if_addr[9:0]]);
        gseq.push_back(1);
      end else if (e_dm) begin
        mq.push_back('{we: dm_we, be: dm_be, addr: dm_addr, wdata: dm_wdata});
        if (dm_we) begin
          q_dm.push_back(32'h0);
          ref_mem[dm_addr[9:0]] = merge(ref_mem[dm_addr[9:0]], dm_wdata, dm_be);
        end else begin
          q_dm.push_back(ref_mem[dm_addr[9:0]]);
        end
        gseq.push_back(0);
      end
      if (if_gnt) if_taken = 1;
      if (dm_gnt) dm_taken = 1;

      if (mem_req) begin
        if (mq.size() == 0) bad("mem_req_unexpected");
        else begin
          t = mq[0];
          chk("mem_ctl", {mem_we, mem_be, mem_addr}, {t.we, t.be, t.addr});
          if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
          if (mem_ready) begin
            void'(mq.pop_front());
            hs = 1; hs_we = mem_we; hs_be = mem_be; hs_addr = mem_addr; hs_wdata = mem_wdata;
          end
        end
      end
    end
  end

  // Memory device: independent storage, random ready and response delay; survives DUT reset.
  always @(posedge clk) begin : dev
    #1;
    if (hs) begin
      hs = 0;
      if (hs_we) begin
        dev_mem[hs_addr[9:0]] = merge(dev_mem[hs_addr[9:0]], hs_wdata, hs_be);
        rsp_dat = $urandom;
      end else begin
        rsp_dat = dev_mem[hs_addr[9:0]];
      end
      rsp_pend = 1;
      rsp_cnt  = int'($urandom_range(rsp_max, rsp_min));
    end
    mem_ready  = ($urandom_range(0, 99) < ready_pct);
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (rsp_pend) begin
      if (rsp_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rsp_dat;
        rsp_pend   = 0;
      end else begin
        rsp_cnt--;
      end
    end
  end

  always @(posedge clk) begin : drv
    #1;
    if (rand_on) begin
      if (if_taken || !if_req) begin
        if_req  = ($urandom_range(0, 99) < if_pct);
        if_addr = $urandom_range(0, 1023);
      end
      if (dm_taken || !dm_req) begin
        dm_req   = ($urandom_range(0, 99) < dm_pct);
        dm_we    = 1'($urandom_range(0, 1));
        dm_be    = 4'($urandom_range(1, 15));
        dm_addr  = $urandom_range(0, 1023);
        dm_wdata = $urandom;
      end
    end
    if_taken = 0;
    dm_taken = 0;
  end

  task automatic wait_gnt(input bit is_if, output int c);
    c = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (is_if ? if_gnt : dm_gnt) begin c = cyc; break; end
    end
    if (c < 0) bad(is_if ? "if_gnt_timeout" : "dm_gnt_timeout");
  endtask

  task automatic wait_rv(input bit is_if, output int c);
    c = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (is_if ? if_rvalid : dm_rvalid) begin c = cyc; break; end
    end
    if (c < 0) bad(is_if ? "if_rvalid_timeout" : "dm_rvalid_timeout");
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = !if_req && !dm_req && !m_busy && !rsp_pend &&
             mq.size() == 0 && q_if.size() == 0 && q_dm.size() == 0;
    end
    if (!done) bad("drain_timeout");
  endtask

  initial begin : main
    int t0, t1, n;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
      dev_mem[i] = ref_mem[i];
    end
    ref_mem[10'h100] = 32'h0000_0013;
    dev_mem[10'h100] = 32'h0000_0013;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ctl", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, mem_be, err}, 0);
    chk("rst_data", {if_rdata, dm_rdata, mem_addr}, 0);
    chk("rst_wdata", mem_wdata, 0);

    // Lone fetch with an immediate memory: minimum latency.
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h100;
    wait_gnt(1, t0);
    @(posedge clk); #1 if_req = 1'b0;
    wait_rv(1, t1);
    chk("lone_fetch_latency", 96'(t1 - t0), 96'(3));
    chk("lone_fetch_rdata", if_rdata, 32'h13);

    // Simultaneous requests: data first, fetch granted in the data rvalid cycle.
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h200; dm_wdata = 32'h0;
    @(negedge clk);
    chk("contend_first_gnt", {if_gnt, dm_gnt}, 2'b01);
    @(posedge clk); #1 dm_req = 1'b0;
    wait_gnt(1, t0);
    chk("contend_if_in_rv_cycle", dm_rvalid, 1);
    @(posedge clk); #1 if_req = 1'b0;
    drain();

    // Store stalled by mem_ready for three cycles.
    ready_pct = 0;
    @(posedge clk); #1 dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h300; dm_wdata = 32'hDEAD_BEEF;
    wait_gnt(0, t0);
    @(posedge clk); #1 dm_req = 1'b0;
    n = 0;
    repeat (3) begin @(negedge clk); if (mem_req && !mem_ready) n++; end
    ready_pct = 100;
    @(negedge clk); if (mem_req && mem_ready) n++;
    chk("store_mem_req_hold", 96'(n), 96'(4));
    wait_rv(0, t1);
    chk("store_rdata_zero", dm_rdata, 0);
    drain();

    // Both requesters saturated: MAXB data grants then one fetch, repeating.
    gseq.delete();
    if_pct = 100; dm_pct = 100; rand_on = 1;
    for (int i = 0; i < 300 && gseq.size() < 10; i++) @(negedge clk);
    if (gseq.size() < 10) bad("burst_seq_timeout");
    else for (int k = 0; k < 10; k++) chk("burst_seq", 96'(gseq[k]), 96'((k % 5 == 4) ? 1 : 0));
    if_pct = 0; dm_pct = 0;
    drain();
    rand_on = 0;

    // Random traffic, light then heavy contention.
    ready_pct = 70; rsp_max = 2; if_pct = 40; dm_pct = 60; rand_on = 1;
    repeat (3000) @(negedge clk);
    ready_pct = 50; if_pct = 90; dm_pct = 90;
    repeat (1500) @(negedge clk);
    if_pct = 0; dm_pct = 0;
    drain();
    rand_on = 0;
    chk("err_clean", err, 0);

    // Reset while waiting for a load response; the late response is stray.
    ready_pct = 100; rsp_min = 3; rsp_max = 3;
    @(posedge clk); #1 dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h10;
    wait_gnt(0, t0);
    @(posedge clk); #1 dm_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    repeat (6) begin @(negedge clk); if (dm_rvalid) n++; end
    chk("rst_abandon_no_rvalid", 96'(n), 96'(0));
    chk("stray_rvalid_err", err, 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("err_clear_on_rst", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    bad("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_DM_BURST, default 4, consecutive data grants allowed while a fetch waits before fetch is forced (range 1..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 if_req  input  1  fetch request; held with if_addr until if_gnt.
REQ-005 if_addr  input  32  fetch word address.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid  output  1  one-cycle pulse; if_rdata valid.
REQ-008 if_rdata  output  32  fetched instruction.
REQ-009 dm_req  input  1  data request; held with dm_we/dm_be/dm_addr/dm_wdata until dm_gnt.
REQ-010 dm_we  input  1  1 = store, 0 = load.
REQ-011 dm_be  input  4  store byte enables.
REQ-012 dm_addr  input  32  data address.
REQ-013 dm_wdata  input  32  store data.
REQ-014 dm_gnt  output  1  data request accepted this cycle.
REQ-015 dm_rvalid  output  1  one-cycle pulse; load data valid or store complete.
REQ-016 dm_rdata  output  32  load data; 0 for stores.
REQ-017 mem_req, mem_we, mem_be[4], mem_addr[32], mem_wdata[32]  outputs  registered request to the shared single-port memory.
REQ-018 mem_ready  input  1  memory accepts mem_req this cycle.
REQ-019 mem_rvalid  input  1  memory response (loads and stores); mem_rdata  input  32.
REQ-020 err  output  1  sticky: mem_rvalid seen outside a response-wait state.

Function
REQ-021 FSM states: IDLE, REQ_IF, REQ_DM, RSP_IF, RSP_DM; at most one memory transaction outstanding.
REQ-022 IDLE: if any request pending, select one, assert its gnt combinationally that cycle, latch the request into the mem_* registers, and go to REQ_IF/REQ_DM; else stay.
REQ-023 Selection: dm_req wins over if_req, except if_req wins when burst count == MAX_DM_BURST.
REQ-024 Burst count (4 bits): +1 on each dm grant while if_req is high, saturating at MAX_DM_BURST; cleared on each if grant or when if_req is low in IDLE.
REQ-025 REQ_x: mem_req=1 with stable fields; on mem_ready=1 go to RSP_x and drop mem_req next cycle; otherwise hold indefinitely.
REQ-026 RSP_x: wait for mem_rvalid; on it, register mem_rdata (dm store: 0) into x_rdata, pulse x_rvalid next cycle, and return to IDLE.
REQ-027 Minimum latency: gnt at cycle T, mem_req T+1, mem_ready T+1, mem_rvalid T+2, x_rvalid T+3, next gnt possible at T+3.
REQ-028 gnt is never asserted outside IDLE; both gnts are never high together; rvalid pulses exactly once per gnt.
REQ-029 mem_rvalid in IDLE or REQ_x is ignored for data and sets err; err clears only on rst.
REQ-030 mem_we=0 and mem_be=4'hF for fetches; x_rdata holds its last value between pulses.

Reset
REQ-031 rst=1 at a clock edge: state IDLE, burst count 0, err 0, all outputs 0 from the next cycle, regardless of the current state.
REQ-032 Reset mid-transaction abandons it with no rvalid; a later stray mem_rvalid sets err per REQ-029.

Verification
REQ-033 if_req only, addr 0x100, mem_ready=1, mem_rvalid at T+2 with 0x00000013 -> if_gnt T, if_rvalid T+3, if_rdata 0x00000013.
REQ-034 if_req and dm_req together, dm_we=0 -> dm_gnt first; if_gnt after dm_rvalid, in the IDLE cycle.
REQ-035 dm_req held high continuously plus if_req, MAX_DM_BURST=4 -> 4 dm grants, then 1 if grant, then dm resumes.
REQ-036 Store dm_be=4'b0011, mem_ready low for 3 cycles -> mem_req held 4 cycles with fields unchanged; dm_rvalid=1 and dm_rdata=0 after mem_rvalid.
REQ-037 rst asserted in RSP_DM, then mem_rvalid 2 cycles later -> no dm_rvalid, err=1 until the next rst.
